exec_wb: RTL and testbench

EXEC_WB -- requirements
Module: exec_wb

---
 rtl/exec_wb.sv | 137 +++++++++++++
 tb/tb_exec_wb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_wb.sv
// exec_wb: execute/write-back stage for a small accumulator-style datapath.
// Single-cycle ALU ops go straight to write-back; shifts run one bit per
// cycle and MUL runs a DW-step shift-add before write-back.
module exec_wb #(
    parameter int DW    = 8,
    parameter int count = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [count-2:0]     rs_idx,
    input  logic [DW-1:0]        rs_val,
    input  logic [DW-1:0]        rt_val,
    output logic                 busy,
    output logic                 write_enable,
    output logic [count-2:0]     rs_wr,
    output logic [DW-1:0]        write_data,
    output logic                 cout_write_enable,
    output logic [DW-1:0]        cout_data
);

    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [count-2:0] rs_q;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    res_lo;
    logic [DW-1:0]    res_hi;
    logic [CW-1:0]    cnt;

    logic [DW:0]      add_sum;
    logic [DW:0]      mul_sum;

    // Adder for ADD carry and the partial-product accumulate step of MUL.
    // During MUL, res_hi holds the running high half and res_lo the
    // remaining multiplier bits (consumed LSB first).
    always_comb begin
        add_sum = {1'b0, rs_val} + {1'b0, rt_val};
        mul_sum = {1'b0, res_hi} + (res_lo[0] ? {1'b0, a_q} : '0);
    end

    // Control FSM and datapath registers. Operands are captured only when
    // start is accepted in IDLE, so later input changes cannot disturb a
    // running operation, and start is simply not looked at in RUN or WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            rs_q   <= '0;
            a_q    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        rs_q   <= rs_idx;
                        a_q    <= rs_val;
                        res_hi <= '0;
                        cnt    <= '0;
                        state  <= ST_WB;
                        case (op)
                            OP_ADD: begin
                                res_lo <= add_sum[DW-1:0];
                                res_hi <= {{(DW-1){1'b0}}, add_sum[DW]};
                            end
                            OP_SUB: begin
                                res_lo <= rs_val - rt_val;
                                res_hi <= {{(DW-1){1'b0}}, (rs_val < rt_val)};
                            end
                            OP_AND: res_lo <= rs_val & rt_val;
                            OP_OR:  res_lo <= rs_val | rt_val;
                            OP_SHL, OP_SHR: begin
                                res_lo <= rs_val;
                                cnt    <= CW'(rt_val[2:0]);
                                if (rt_val[2:0] != 3'd0) begin
                                    state <= ST_RUN;
                                end
                            end
                            OP_MUL: begin
                                res_lo <= rt_val;
                                cnt    <= CW'(DW);
                                state  <= ST_RUN;
                            end
                            default: res_lo <= rt_val;
                        endcase
                    end
                end
                ST_RUN: begin
                    case (op_q)
                        OP_SHL: {res_hi, res_lo} <= {res_hi[DW-2:0], res_lo, 1'b0};
                        OP_SHR: {res_lo, res_hi} <= {1'b0, res_lo, res_hi[DW-1:1]};
                        default: {res_hi, res_lo} <= {mul_sum, res_lo[DW-1:1]};
                    endcase
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-back outputs are only driven during WB and read zero otherwise.
    always_comb begin
        busy              = (state != ST_IDLE);
        write_enable      = (state == ST_WB);
        rs_wr             = (state == ST_WB) ? rs_q : '0;
        write_data        = (state == ST_WB) ? res_lo : '0;
        cout_write_enable = (state == ST_WB) && (op_q != OP_MOV);
        cout_data         = (state == ST_WB) ? res_hi : '0;
    end

endmodule

// File: tb/tb_exec_wb.sv
// tb_exec_wb: directed, table-driven bench for exec_wb plus hand-written
// sequences for start-while-busy and mid-operation reset.
module tb_exec_wb;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [1:0] rs_idx;
    logic [7:0] rs_val;
    logic [7:0] rt_val;
    logic       busy;
    logic       write_enable;
    logic [1:0] rs_wr;
    logic [7:0] write_data;
    logic       cout_write_enable;
    logic [7:0] cout_data;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [2:0] op;
        logic [1:0] idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] wd;
        logic [7:0] cd;
        logic       cwe;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    exec_wb #(.DW(8), .count(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .op                (op),
        .rs_idx            (rs_idx),
        .rs_val            (rs_val),
        .rt_val            (rt_val),
        .busy              (busy),
        .write_enable      (write_enable),
        .rs_wr             (rs_wr),
        .write_data        (write_data),
        .cout_write_enable (cout_write_enable),
        .cout_data         (cout_data)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operation for a single accepting edge, then scramble the
    // inputs so that any failure to latch operands shows up in the result.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        start  = 1'b1;
        op     = v.op;
        rs_idx = v.idx;
        rs_val = v.a;
        rt_val = v.b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = ~v.op;
        rs_idx = ~v.idx;
        rs_val = ~v.a;
        rt_val = ~v.b;
    endtask

    // Wait (bounded) for the write strobe, then compare latency and results.
    task automatic run_vector(input int k, input vec_t v);
        int lat;
        lat = 0;
        apply_stimulus(v);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (write_enable) break;
        end
        check_output($sformatf("v%0d latency", k), lat, v.lat);
        check_output($sformatf("v%0d rs_wr", k), rs_wr, v.idx);
        check_output($sformatf("v%0d write_data", k), write_data, v.wd);
        check_output($sformatf("v%0d cout_we", k), cout_write_enable, v.cwe);
        if (v.cwe) check_output($sformatf("v%0d cout_data", k), cout_data, v.cd);
        @(negedge clk);
        check_output($sformatf("v%0d we_one_cycle", k), write_enable, 1'b0);
    endtask

    initial begin
        int we_count;
        int busy_count;
        vec_t v;

        tests_run    = 0;
        tests_failed = 0;

        //              op      idx   a      b      wd     cd     cwe  lat
        vecs[0]  = '{3'b000, 2'd2, 8'hF0, 8'h20, 8'h10, 8'h01, 1'b1, 1};
        vecs[1]  = '{3'b000, 2'd0, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b1, 1};
        vecs[2]  = '{3'b001, 2'd1, 8'h05, 8'h07, 8'hFE, 8'h01, 1'b1, 1};
        vecs[3]  = '{3'b001, 2'd3, 8'h07, 8'h07, 8'h00, 8'h00, 1'b1, 1};
        vecs[4]  = '{3'b010, 2'd1, 8'hCC, 8'hAA, 8'h88, 8'h00, 1'b1, 1};
        vecs[5]  = '{3'b011, 2'd2, 8'hCC, 8'hAA, 8'hEE, 8'h00, 1'b1, 1};
        vecs[6]  = '{3'b111, 2'd3, 8'h55, 8'h3C, 8'h3C, 8'h00, 1'b0, 1};
        vecs[7]  = '{3'b100, 2'd1, 8'h81, 8'h01, 8'h02, 8'h01, 1'b1, 2};
        vecs[8]  = '{3'b101, 2'd0, 8'h81, 8'h00, 8'h81, 8'h00, 1'b1, 1};
        vecs[9]  = '{3'b101, 2'd2, 8'h81, 8'h03, 8'h10, 8'h20, 1'b1, 4};
        vecs[10] = '{3'b100, 2'd3, 8'hB5, 8'hF7, 8'h80, 8'h5A, 1'b1, 8};
        vecs[11] = '{3'b110, 2'd1, 8'h10, 8'h20, 8'h00, 8'h02, 1'b1, 9};
        vecs[12] = '{3'b110, 2'd2, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 9};

        start  = 1'b0;
        op     = 3'b000;
        rs_idx = 2'd0;
        rs_val = 8'h00;
        rt_val = 8'h00;
        reset  = 1'b1;

        // Outputs held at zero while reset is asserted.
        repeat (2) @(negedge clk);
        check_output("rst busy", busy, 1'b0);
        check_output("rst we", write_enable, 1'b0);
        check_output("rst cwe", cout_write_enable, 1'b0);
        check_output("rst rs_wr", rs_wr, 2'd0);
        check_output("rst wd", write_data, 8'h00);
        check_output("rst cd", cout_data, 8'h00);
        reset = 1'b0;

        for (int k = 0; k < 13; k++) begin
            run_vector(k, vecs[k]);
        end

        // ADD start pulse during cycle 3 of a MUL must be ignored.
        $display("[TB] sequence: start while busy");
        v = '{3'b110, 2'd1, 8'h10, 8'h20, 8'h00, 8'h02, 1'b1, 9};
        apply_stimulus(v);
        we_count   = 0;
        busy_count = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start  = 1'b1;
                op     = 3'b000;
                rs_idx = 2'd3;
                rs_val = 8'h01;
                rt_val = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_count++;
            if (write_enable) begin
                we_count++;
                check_output("busy seq wd", write_data, 8'h00);
                check_output("busy seq cd", cout_data, 8'h02);
                check_output("busy seq rs_wr", rs_wr, 2'd1);
            end
        end
        check_output("busy seq we_count", we_count, 1);
        check_output("busy seq busy_cycles", busy_count, 9);

        // Start presented in the WB cycle must be ignored.
        $display("[TB] sequence: start in WB");
        v = '{3'b000, 2'd2, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1, 1};
        apply_stimulus(v);
        @(negedge clk);
        check_output("wb seq we", write_enable, 1'b1);
        start  = 1'b1;
        op     = 3'b111;
        rs_val = 8'h11;
        rt_val = 8'h22;
        @(negedge clk);
        start = 1'b0;
        we_count = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || write_enable) we_count++;
            @(negedge clk);
        end
        check_output("wb seq no_accept", we_count, 0);

        // Reset at cycle 4 of a MUL abandons it with no later strobe.
        $display("[TB] sequence: reset mid MUL");
        v = '{3'b110, 2'd3, 8'h0F, 8'h0F, 8'hE1, 8'h00, 1'b1, 9};
        apply_stimulus(v);
        repeat (3) @(negedge clk);
        check_output("rst seq busy_before", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rst seq busy", busy, 1'b0);
        check_output("rst seq we", write_enable, 1'b0);
        check_output("rst seq cd", cout_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        we_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (write_enable || cout_write_enable || busy) we_count++;
        end
        check_output("rst seq no_strobe", we_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
